mux4_vec_checker: RTL and testbench
===================================

# mux4_vec_checker

Hardware vector sequencer and response checker for the 4:1 mux (`mux4`). It holds a small stimulus/expected-response memory and drives `a0..a3`/`sel` into the mux, one vector per clock. It samples `mux_out` one cycle later, compares it with the expected bit, and reports pass/fail counts plus the first failing address. It is the in-hardware counterpart of the file-driven mux bench: the bench writes vectors into a DUT, and this block reads and judges the DUT's responses.

## Interface
Parameters:
- `DEPTH`, 8: number of vector entries (power of two).
- `AW`, 3: address width, log2(`DEPTH`).

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `load_en`, in, 1: write strobe for the vector memory.
- `load_addr`, in, AW: write address.
- `load_data`, in, 7: vector entry `{a0,a1,a2,a3,sel[1:0],expected}`; bit 6 is `a0`, bit 0 is `expected`.
- `num_vec`, in, AW+1: number of vectors to run, sampled at start.
- `start`, in, 1: pulse that begins a run.
- `mux_out`, in, 1: DUT response.
- `a0`, `a1`, `a2`, `a3`, out, 1 each: registered stimulus to the DUT.
- `sel`, out, 2: registered stimulus to the DUT.
- `busy`, out, 1: a run is in progress.
- `done`, out, 1: a run has completed; sticky.
- `pass_cnt`, out, AW+1: number of matching vectors.
- `fail_cnt`, out, AW+1: number of mismatching vectors.
- `first_fail_addr`, out, AW: address of the first mismatch.
- `first_fail_valid`, out, 1: at least one mismatch has occurred.

## Operation
- Memory:
  - `DEPTH` x 7 bits, written on `clk` when `load_en`=1 and `busy`=0.
  - Writes are ignored while `busy`=1.
  - The memory is not cleared by reset.
- State machine states: IDLE, RUN, DONE.
- IDLE to RUN on `start`=1:
  - Latch `n = min(num_vec, DEPTH)`.
  - Clear `pass_cnt`, `fail_cnt`, `first_fail_valid` and `first_fail_addr`.
  - Set addr=0.
  - Drive `a0..a3`/`sel` from mem[0] on the same edge.
  - Set `busy`=1.
- `start` with `num_vec`=0: go directly to DONE with both counts 0 and `busy` staying 0.
- RUN, on each edge:
  - Compare `mux_out` against `expected` of mem[addr], the vector currently driven.
  - On match, increment `pass_cnt`.
  - On mismatch, increment `fail_cnt`; if `first_fail_valid`=0, set `first_fail_addr`=addr and `first_fail_valid`=1.
  - If addr==n-1: go to DONE, set `busy`=0 and `done`=1. Stimulus outputs hold the last vector.
  - Otherwise: addr+1, and drive mem[addr+1].
- DONE: all outputs hold. `start`=1 begins a new run, exactly as from IDLE, and clears `done`.
- `start` while `busy`=1 is ignored.
- In simulation, an X or Z on `mux_out` counts as a mismatch.
- Counters never wrap: the maximum count is `DEPTH`, which fits in AW+1 bits.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - `a0..a3`=0, `sel`=0.
  - `busy`=0, `done`=0.
  - `pass_cnt`=0, `fail_cnt`=0.
  - `first_fail_addr`=0, `first_fail_valid`=0.
  - State is IDLE.
- Reset takes priority over `start` and `load_en`. A reset mid-run aborts the run; no partial `done` is produced.
- Start edge = T0. Vector k is driven from edge T0+k and compared at edge T0+k+1.
- The DUT gets one full cycle of combinational settling.
- `busy` is high for edges T0..T0+n-1 (n cycles). `done` rises at edge T0+n.
- Counts, `first_fail_*` and `done` are all final at T0+n.
- Throughput: one vector per cycle.
- Start-to-done latency is n cycles, or 1 cycle for `num_vec`=0.
- A `load_en` write at the same edge as an accepted `start` is performed, since `busy` is still 0 at that edge. The new data is visible to vector addr only if it is written before that vector is read.

## Test plan
- **All pass:**
  - Stimulus: load the 8 exhaustive-style vectors with correct expected values, for example `7'b1000_00_1`, `7'b0100_01_1` and so on; connect a real `mux4`; set `num_vec`=8 and pulse `start`.
  - Required response: `done` at T0+8, `pass_cnt`=8, `fail_cnt`=0, `first_fail_valid`=0.
- **Injected errors:**
  - Stimulus: flip the `expected` bit at addresses 2 and 5.
  - Required response: `pass_cnt`=6, `fail_cnt`=2, `first_fail_addr`=2, `first_fail_valid`=1.
- **Length boundaries:**
  - `num_vec`=0: `done` after 1 cycle, both counts 0.
  - `num_vec`=1: `done` at T0+1, count total 1.
  - `num_vec`=12: clamped to 8, count total 8.
- **Ignored inputs while busy:**
  - Stimulus: assert `start` and `load_en` during RUN, writing address 7.
  - Required response: the run continues unchanged, with total 8 and the old mem[7] content used. After `done`, the write is confirmed ignored by rerunning.
- **Reset mid-run:**
  - Stimulus: `rst_n`=0 at T0+3.
  - Required response: all outputs at reset values on the next edge. A subsequent `start` produces a full, correct run, since the memory contents were retained.
- **Back-to-back runs:**
  - Stimulus: `start` while in DONE.
  - Required response: `done` drops, counts clear on the same edge, and the second run produces results identical to the first.

Source files
------------

// File: rtl/mux4_vec_checker.sv
// Vector sequencer and response checker for a 4:1 mux: replays stored stimulus
// one vector per clock and judges the mux response one cycle later.
`timescale 1ns/1ps
module mux4_vec_checker #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [6:0]    load_data,
  input  logic [AW:0]   num_vec,
  input  logic          start,
  input  logic          mux_out,
  output logic          a0,
  output logic          a1,
  output logic          a2,
  output logic          a3,
  output logic [1:0]    sel,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   pass_cnt,
  output logic [AW:0]   fail_cnt,
  output logic [AW-1:0] first_fail_addr,
  output logic          first_fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_ADR = AW'(1);

  // state is kept as a named signal so checkers can bind to it directly
  state_t        state;
  state_t        state_nxt;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic [AW:0]   n;
  logic [AW:0]   n_clamp;
  logic          exp_bit;
  logic          zero_run;
  logic          last;
  logic [6:0]    vec_first;
  logic [6:0]    vec_next;

  // Vector memory: no reset, writes locked out while a run is active.
  always_ff @(posedge clk) begin
    if (rst_n && load_en && !busy) mem[load_addr] <= load_data;
  end

  always_comb begin
    n_clamp   = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;
    zero_run  = (num_vec == '0);
    last      = ({1'b0, addr} == (n - ONE_CNT));
    addr_inc  = addr + ONE_ADR;
    vec_first = mem[0];
    vec_next  = mem[addr_inc];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = zero_run ? DONE : RUN;
      RUN:        if (last)  state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Datapath. The expected bit is latched with the stimulus so the judgement
  // always refers to exactly the vector the mux is seeing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {a0, a1, a2, a3} <= 4'b0;
      sel              <= 2'b0;
      exp_bit          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_addr  <= '0;
      first_fail_valid <= 1'b0;
      addr             <= '0;
      n                <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_addr  <= '0;
            first_fail_valid <= 1'b0;
            n                <= n_clamp;
            addr             <= '0;
            if (zero_run) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              busy                  <= 1'b1;
              done                  <= 1'b0;
              {a0, a1, a2, a3, sel} <= vec_first[6:1];
              exp_bit               <= vec_first[0];
            end
          end
        end
        RUN: begin
          // An unknown response makes the equality false and lands on the fail side.
          if (mux_out == exp_bit) begin
            pass_cnt <= pass_cnt + ONE_CNT;
          end else begin
            fail_cnt <= fail_cnt + ONE_CNT;
            if (!first_fail_valid) begin
              first_fail_addr  <= addr;
              first_fail_valid <= 1'b1;
            end
          end
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            addr                  <= addr_inc;
            {a0, a1, a2, a3, sel} <= vec_next[6:1];
            exp_bit               <= vec_next[0];
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_vec_checker.sv
// Bench for mux4_vec_checker: an ideal mux closes the loop, and a vector-level
// model predicts the stimulus stream, counts and first failing address.
`timescale 1ns/1ps
module tb_mux4_vec_checker;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [6:0]    load_data;
  logic [AW:0]   num_vec;
  logic          start;
  logic          mux_out;
  logic          a0, a1, a2, a3;
  logic [1:0]    sel;
  logic          busy, done;
  logic [AW:0]   pass_cnt, fail_cnt;
  logic [AW-1:0] first_fail_addr;
  logic          first_fail_valid;

  logic          mux_bad;
  logic          mux_ideal;
  logic [6:0]    tb_mem [DEPTH];
  logic [5:0]    exp_q [$];
  int            n_checks;
  int            n_errors;

  mux4_vec_checker #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start), .mux_out(mux_out),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .sel(sel), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_addr(first_fail_addr),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      2'd0:    mux_ideal = a0;
      2'd1:    mux_ideal = a1;
      2'd2:    mux_ideal = a2;
      default: mux_ideal = a3;
    endcase
  end
  assign mux_out = mux_ideal ^ mux_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Vector-level prediction: which entries run, what the mux answers, and the verdicts.
  task automatic model(input int nv, output int n, output int pass, output int fail,
                       output int ffa, output bit ffv);
    logic [6:0] v;
    int s;
    bit resp;
    n = (nv > DEPTH) ? DEPTH : nv;
    pass = 0; fail = 0; ffa = 0; ffv = 1'b0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      v = tb_mem[k];
      s = int'(v[2:1]);
      resp = v[6 - s] ^ mux_bad;
      exp_q.push_back(v[6:1]);
      if (resp == v[0]) pass++;
      else begin
        fail++;
        if (!ffv) begin ffv = 1'b1; ffa = k; end
      end
    end
  endtask

  task automatic load(input int addr, input logic [6:0] data);
    @(negedge clk);
    load_en = 1'b1; load_addr = AW'(addr); load_data = data;
    @(posedge clk); #1;
    load_en = 1'b0;
    tb_mem[addr] = data;
  endtask

  function automatic logic [6:0] good_vec(input logic flip);
    logic [3:0] a;
    int s;
    a = 4'($urandom_range(0, 15));
    s = $urandom_range(0, 3);
    return {a, 2'(s), a[3 - s] ^ flip};
  endfunction

  task automatic run_vec(input int nv, input bit poke);
    int n, pass, fail, ffa;
    bit ffv;
    model(nv, n, pass, fail, ffa, ffv);
    @(negedge clk);
    start = 1'b1; num_vec = (AW+1)'(nv);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      check("zero_busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      check("zero_done", done, 1);
      check("zero_counts", {pass_cnt, fail_cnt}, 0);
      check("zero_ffv", first_fail_valid, 0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("run_busy", busy, 1);
      check("run_done_low", done, 0);
      if (exp_q.size() == 0) check("stim_queue_empty", 1, 0);
      else check("stim", {a0, a1, a2, a3, sel}, exp_q.pop_front());
      if (k == 0) begin
        check("cnt_cleared", {pass_cnt, fail_cnt}, 0);
        check("ffv_cleared", first_fail_valid, 0);
      end
      if (poke && k == 2) begin
        start = 1'b1; load_en = 1'b1; load_addr = 3'd7; load_data = ~tb_mem[7];
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("pass_cnt", pass_cnt, pass);
    check("fail_cnt", fail_cnt, fail);
    check("ffv", first_fail_valid, ffv);
    check("ffa", first_fail_addr, ffa);
    check("stim_hold", {a0, a1, a2, a3, sel}, tb_mem[n - 1][6:1]);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    num_vec = '0; start = 1'b0; mux_bad = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stim", {a0, a1, a2, a3, sel}, 0);
    check("rst_flags", {busy, done, first_fail_valid}, 0);
    check("rst_counts", {pass_cnt, fail_cnt, first_fail_addr}, 0);
    rst_n = 1'b1;

    // All pass with an ideal mux
    for (int i = 0; i < DEPTH; i++) load(i, good_vec(1'b0));
    run_vec(8, 1'b0);
    check("allpass_pass", pass_cnt, 8);

    // Injected expectation errors at 2 and 5
    load(2, tb_mem[2] ^ 7'd1);
    load(5, tb_mem[5] ^ 7'd1);
    run_vec(8, 1'b0);
    check("inj_pass", pass_cnt, 6);
    check("inj_fail", fail_cnt, 2);
    check("inj_ffa", first_fail_addr, 2);

    // Length boundaries
    run_vec(0, 1'b0);
    run_vec(1, 1'b0);
    run_vec(12, 1'b0);

    // start/load while busy are ignored; rerun confirms mem[7] unchanged
    run_vec(8, 1'b1);
    run_vec(8, 1'b0);

    // Reset in the middle of a run
    @(negedge clk);
    start = 1'b1; num_vec = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_stim", {a0, a1, a2, a3, sel}, 0);
    check("midrst_flags", {busy, done, first_fail_valid}, 0);
    check("midrst_counts", {pass_cnt, fail_cnt, first_fail_addr}, 0);
    rst_n = 1'b1;
    run_vec(8, 1'b0);

    // Back-to-back runs from DONE
    run_vec(8, 1'b0);
    run_vec(8, 1'b0);

    // Broken mux: every compare fails
    mux_bad = 1'b1;
    run_vec(5, 1'b0);
    mux_bad = 1'b0;

    // Random contents and lengths
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++)
        if ($urandom_range(0, 1) == 1) load(i, good_vec(1'($urandom_range(0, 3) == 0)));
      run_vec($urandom_range(0, 15), 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
